// File: rtl/prog_sequencer.sv
// Program launch sequencer: launches NUM_PROGS programs back to back, times each
// program's RUN phase and aborts a run that exceeds TIMEOUT cycles.
module prog_sequencer #(
   parameter int          NUM_PROGS = 3,
   parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic        DONE,
   output logic        Init,
   output logic [1:0]  ProgIdx,
   output logic        Busy,
   output logic [15:0] LastCycles,
   output logic        LastValid,
   output logic        AllDone,
   output logic        Timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_FINISH,
      S_ERROR
   } state_t;

   localparam logic [1:0]  LAST_IDX = 2'(NUM_PROGS - 1);
   localparam logic [15:0] LAST_CNT = TIMEOUT - 16'd1;

   state_t      state_reg, state_next;
   logic [15:0] count_reg, count_next;
   logic [1:0]  prog_reg, prog_next;
   logic [15:0] last_reg, last_next;
   logic        lv_reg, lv_next;
   logic        init_reg, init_next;
   logic        alldone_reg, alldone_next;
   logic        tout_reg, tout_next;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg   <= S_IDLE;
         count_reg   <= 16'd0;
         prog_reg    <= 2'd0;
         last_reg    <= 16'd0;
         lv_reg      <= 1'b0;
         init_reg    <= 1'b0;
         alldone_reg <= 1'b0;
         tout_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         prog_reg    <= prog_next;
         last_reg    <= last_next;
         lv_reg      <= lv_next;
         init_reg    <= init_next;
         alldone_reg <= alldone_next;
         tout_reg    <= tout_next;
      end
   end

   // Init is registered from the decision to enter LAUNCH, so it is high
   // exactly while the state register holds LAUNCH.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      prog_next    = prog_reg;
      last_next    = last_reg;
      lv_next      = 1'b0;
      init_next    = 1'b0;
      alldone_next = alldone_reg;
      tout_next    = tout_reg;

      case (state_reg)
         S_IDLE, S_FINISH, S_ERROR: begin
            if (Start) begin
               state_next   = S_LAUNCH;
               prog_next    = 2'd0;
               alldone_next = 1'b0;
               tout_next    = 1'b0;
               count_next   = 16'd0;
               init_next    = 1'b1;
            end
         end

         S_LAUNCH: begin
            state_next = S_RUN;
            count_next = 16'd0;
         end

         S_RUN: begin
            // Completion wins over the timeout check on the same cycle.
            if (DONE) begin
               last_next = count_reg;
               lv_next   = 1'b1;
               if (prog_reg == LAST_IDX) begin
                  state_next   = S_FINISH;
                  alldone_next = 1'b1;
               end else begin
                  prog_next  = prog_reg + 2'd1;
                  state_next = S_LAUNCH;
                  init_next  = 1'b1;
               end
            end else if (count_reg == LAST_CNT) begin
               tout_next  = 1'b1;
               state_next = S_ERROR;
            end else begin
               count_next = count_reg + 16'd1;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign Busy       = (state_reg == S_LAUNCH) || (state_reg == S_RUN);
   assign Init       = init_reg;
   assign ProgIdx    = prog_reg;
   assign LastCycles = last_reg;
   assign LastValid  = lv_reg;
   assign AllDone    = alldone_reg;
   assign Timeout    = tout_reg;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: fetch-unit models drive DONE, a behavioural model
// predicts every output each cycle, plus directed literal checks per run.
`timescale 1ns/1ps
module tb_prog_sequencer;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic Reset, Start1, Start2, force_done;
   logic fdone1 = 1'b0, fdone2 = 1'b0;
   logic DONE1, DONE2;
   assign DONE1 = fdone1 | force_done;
   assign DONE2 = fdone2;

   logic        init1, busy1, lv1, all1, tout1;
   logic [1:0]  prog1;
   logic [15:0] last1;
   logic        init2, busy2, lv2, all2, tout2;
   logic [1:0]  prog2;
   logic [15:0] last2;

   prog_sequencer #(.NUM_PROGS(3)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start1), .DONE(DONE1),
      .Init(init1), .ProgIdx(prog1), .Busy(busy1), .LastCycles(last1),
      .LastValid(lv1), .AllDone(all1), .Timeout(tout1)
   );

   prog_sequencer #(.NUM_PROGS(3), .TIMEOUT(16'd8)) dut_to (
      .CLK(CLK), .Reset(Reset), .Start(Start2), .DONE(DONE2),
      .Init(init2), .ProgIdx(prog2), .Busy(busy2), .LastCycles(last2),
      .LastValid(lv2), .AllDone(all2), .Timeout(tout2)
   );

   // Fetch models: DONE rises after dur[n] RUN cycles of the n-th launch (0 = never).
   int dur1[16] = '{10, 20, 30, 3, 1, 5, 4, 50, 2, 2, 2, 0, 0, 0, 0, 0};
   int dur2[16] = '{7, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   int fi1 = 0, fcnt1 = 0, fdur1 = 0;
   int fi2 = 0, fcnt2 = 0, fdur2 = 0;

   always @(posedge CLK) begin
      if (init1 === 1'b1) begin
         fdur1 <= dur1[fi1]; fi1 <= fi1 + 1; fcnt1 <= 0; fdone1 <= 1'b0;
      end else begin
         fcnt1 <= fcnt1 + 1;
         if (fdur1 != 0 && fcnt1 + 1 == fdur1) fdone1 <= 1'b1;
      end
      if (init2 === 1'b1) begin
         fdur2 <= dur2[fi2]; fi2 <= fi2 + 1; fcnt2 <= 0; fdone2 <= 1'b0;
      end else begin
         fcnt2 <= fcnt2 + 1;
         if (fdur2 != 0 && fcnt2 + 1 == fdur2) fdone2 <= 1'b1;
      end
   end

   // Behavioural model of the sequencing rules.
   localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_FINISH = 3, M_ERROR = 4;
   typedef struct {
      int phase; int prog; int cnt; int last;
      bit lv; bit init; bit alld; bit tout;
   } mst_t;

   function automatic mst_t mstep(mst_t s, bit rst, bit st, bit dn, int nprog, int tmo);
      mst_t r;
      r = s;
      r.lv = 1'b0;
      r.init = 1'b0;
      if (rst) begin
         r = '{M_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
         return r;
      end
      if (s.phase == M_LAUNCH) begin
         r.phase = M_RUN; r.cnt = 0;
      end else if (s.phase == M_RUN) begin
         if (dn) begin
            r.last = s.cnt; r.lv = 1'b1;
            if (s.prog < nprog - 1) begin
               r.prog = s.prog + 1; r.phase = M_LAUNCH; r.init = 1'b1;
            end else begin
               r.phase = M_FINISH; r.alld = 1'b1;
            end
         end else if (s.cnt == tmo - 1) begin
            r.tout = 1'b1; r.phase = M_ERROR;
         end else begin
            r.cnt = s.cnt + 1;
         end
      end else if (st) begin
         r.phase = M_LAUNCH; r.prog = 0; r.alld = 1'b0; r.tout = 1'b0;
         r.cnt = 0; r.init = 1'b1;
      end
      return r;
   endfunction

   mst_t m1 = '{M_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
   mst_t m2 = '{M_IDLE, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

   always @(posedge CLK) begin
      m1 = mstep(m1, Reset, Start1, DONE1, 3, 65535);
      m2 = mstep(m2, Reset, Start2, DONE2, 3, 8);
   end

   int vectors = 0, miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      vectors++;
      if (act !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic budget_fail(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: cycle budget expired", nm);
   endtask

   // Compare process plus logs used by the literal checks.
   bit chk_en = 1'b0;
   int cyc = 0, n_init1 = 0, n_init2 = 0, t_init2 = 0, t_tout2 = 0;
   logic prev_init1 = 1'b0, prev_init2 = 1'b0, prev_tout2 = 1'b0;
   int lc_log[$], pi_log[$], lc_log2[$];

   always @(negedge CLK) begin
      cyc++;
      if (chk_en) begin
         chk("init1", init1, int'(m1.init));
         chk("prog1", prog1, m1.prog);
         chk("busy1", busy1, int'(m1.phase == M_LAUNCH || m1.phase == M_RUN));
         chk("last1", last1, m1.last);
         chk("lv1", lv1, int'(m1.lv));
         chk("alldone1", all1, int'(m1.alld));
         chk("timeout1", tout1, int'(m1.tout));
         chk("init2", init2, int'(m2.init));
         chk("prog2", prog2, m2.prog);
         chk("busy2", busy2, int'(m2.phase == M_LAUNCH || m2.phase == M_RUN));
         chk("last2", last2, m2.last);
         chk("lv2", lv2, int'(m2.lv));
         chk("alldone2", all2, int'(m2.alld));
         chk("timeout2", tout2, int'(m2.tout));
         if (init1 === 1'b1) begin
            chk("init1_gap", prev_init1, 0);
            n_init1++; pi_log.push_back(int'(prog1));
         end
         if (init2 === 1'b1) begin
            chk("init2_gap", prev_init2, 0);
            n_init2++;
            if (prog2 == 2'd1) t_init2 = cyc;
         end
         if (lv1 === 1'b1) lc_log.push_back(int'(last1));
         if (lv2 === 1'b1) lc_log2.push_back(int'(last2));
         if (tout2 === 1'b1 && prev_tout2 !== 1'b1) t_tout2 = cyc;
      end
      prev_init1 = init1;
      prev_init2 = init2;
      prev_tout2 = tout2;
   end

   task automatic tick();
      @(posedge CLK); #2;
   endtask

   task automatic pulse_start(input int which);
      if (which == 1) Start1 = 1'b1; else Start2 = 1'b1;
      tick();
      Start1 = 1'b0; Start2 = 1'b0;
   endtask

   task automatic wait_idle(input int which, input int budget);
      int k = 0;
      while (((which == 1) ? busy1 : busy2) && k < budget) begin
         tick(); k++;
      end
      if ((which == 1) ? busy1 : busy2) budget_fail("wait_idle");
      tick();
   endtask

   task automatic check_run(input string nm, input int e0, input int e1, input int e2);
      int e[3];
      e = '{e0, e1, e2};
      chk({nm, "_nlast"}, lc_log.size(), 3);
      chk({nm, "_ninit"}, pi_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < lc_log.size()) chk({nm, "_cycles"}, lc_log[i], e[i]);
         if (i < pi_log.size()) chk({nm, "_progidx"}, pi_log[i], i);
      end
      chk({nm, "_alldone"}, all1, 1);
      chk({nm, "_progheld"}, prog1, 2);
      lc_log.delete(); pi_log.delete();
   endtask

   initial begin
      int k;
      Reset = 1'b1; Start1 = 1'b0; Start2 = 1'b0; force_done = 1'b0;
      @(posedge CLK); #1; chk_en = 1'b1; #1;
      tick();
      Reset = 1'b0;
      repeat (5) tick();
      chk("idle_inits", n_init1 + n_init2, 0);
      chk("idle_outs1", {busy1, lv1, all1, tout1, prog1, last1}, 0);

      // Run 1: program lengths 10, 20, 30.
      pulse_start(1);
      wait_idle(1, 200);
      check_run("run1", 10, 20, 30);

      // Run 2: Start held during RUN must not add launches.
      Start1 = 1'b1;
      tick();
      k = 0;
      while (busy1 && k < 200) begin
         Start1 = (prog1 != 2'd2);
         tick(); k++;
      end
      Start1 = 1'b0;
      if (busy1) budget_fail("run2_wait");
      tick();
      check_run("run2", 3, 1, 5);

      // Run 3: reset together with DONE in the RUN phase of program 1.
      pulse_start(1);
      k = 0;
      while (!(busy1 && prog1 == 2'd1 && !init1) && k < 100) begin
         tick(); k++;
      end
      if (!(busy1 && prog1 == 2'd1)) budget_fail("run3_wait");
      Reset = 1'b1; force_done = 1'b1;
      tick();
      Reset = 1'b0; force_done = 0;
      chk("rst_lv", lv1, 0);
      chk("rst_busy", busy1, 0);
      repeat (5) tick();
      chk("rst_nlast", lc_log.size(), 1);
      if (lc_log.size() > 0) chk("rst_cycles", lc_log[0], 4);
      chk("rst_ninit", pi_log.size(), 2);
      chk("rst_idle", {busy1, all1, prog1, last1}, 0);
      lc_log.delete(); pi_log.delete();

      // Run 4: fresh start after reset.
      pulse_start(1);
      wait_idle(1, 100);
      check_run("run4", 2, 2, 2);

      // Timeout instance: program 0 completes at the last legal count, program 1 aborts.
      pulse_start(2);
      wait_idle(2, 100);
      chk("to_nlast", lc_log2.size(), 1);
      if (lc_log2.size() > 0) chk("to_edge_cycles", lc_log2[0], 7);
      chk("to_flag", tout2, 1);
      chk("to_alldone", all2, 0);
      chk("to_prog", prog2, 1);
      chk("to_latency", t_tout2 - t_init2, 9);
      lc_log2.delete();

      pulse_start(2);
      chk("relaunch_tout", tout2, 0);
      chk("relaunch_prog", prog2, 0);
      wait_idle(2, 100);
      chk("relaunch_nlast", lc_log2.size(), 3);
      for (int i = 0; i < 3 && i < lc_log2.size(); i++) chk("relaunch_cycles", lc_log2[i], 2);
      chk("relaunch_alldone", all2, 1);
      chk("relaunch_inits", n_init2, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
